// File: rtl/mem_access.sv
// Memory-access pipeline stage: serialises loads/stores over a byte-wide shared
// memory port and stalls the pipeline until the access completes.
module mem_access #(
  parameter int unsigned      AOP_W  = 8,
  parameter logic [AOP_W-1:0] OP_LB  = 8'h20,
  parameter logic [AOP_W-1:0] OP_LH  = 8'h21,
  parameter logic [AOP_W-1:0] OP_LW  = 8'h22,
  parameter logic [AOP_W-1:0] OP_LBU = 8'h23,
  parameter logic [AOP_W-1:0] OP_LHU = 8'h24,
  parameter logic [AOP_W-1:0] OP_SB  = 8'h25,
  parameter logic [AOP_W-1:0] OP_SH  = 8'h26,
  parameter logic [AOP_W-1:0] OP_SW  = 8'h27
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       wd_i,
  input  logic             wreg_i,
  input  logic [31:0]      wdata_i,
  input  logic [AOP_W-1:0] aluop_i,
  input  logic [31:0]      mem_addr_i,
  output logic [4:0]       wd_o,
  output logic             wreg_o,
  output logic [31:0]      wdata_o,
  output logic             stall_req_o,
  output logic             mem_req_o,
  input  logic             mem_gnt_i,
  output logic [31:0]      mem_a_o,
  output logic [7:0]       mem_dout_o,
  output logic             mem_wr_o,
  input  logic [7:0]       mem_din_i
);

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, DONE} state_t;

  state_t      state;
  logic [2:0]  cnt;
  logic [31:0] load_buf;
  logic        is_load;
  logic        is_store;
  logic        is_mem;
  logic [2:0]  nbytes;
  logic [1:0]  lane_prev;
  logic [31:0] load_val;

  always_comb begin
    is_load  = (aluop_i == OP_LB) || (aluop_i == OP_LH) || (aluop_i == OP_LW) ||
               (aluop_i == OP_LBU) || (aluop_i == OP_LHU);
    is_store = (aluop_i == OP_SB) || (aluop_i == OP_SH) || (aluop_i == OP_SW);
    is_mem   = is_load || is_store;
    nbytes   = 3'd4;
    if ((aluop_i == OP_LB) || (aluop_i == OP_LBU) || (aluop_i == OP_SB))
      nbytes = 3'd1;
    else if ((aluop_i == OP_LH) || (aluop_i == OP_LHU) || (aluop_i == OP_SH))
      nbytes = 3'd2;
  end

  // Read data lags its address by one cycle, so each capture targets the previous lane.
  assign lane_prev = cnt[1:0] - 2'd1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      cnt      <= '0;
      load_buf <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (is_mem && mem_gnt_i) begin
            state    <= ACCESS;
            cnt      <= '0;
            load_buf <= '0;
          end
        end
        ACCESS: begin
          if (is_load && (cnt != 3'd0))
            load_buf[{lane_prev, 3'b000} +: 8] <= mem_din_i;
          cnt <= cnt + 3'd1;
          if (cnt == nbytes - 3'd1)
            state <= is_load ? WAIT : DONE;
        end
        WAIT: begin
          load_buf[{lane_prev, 3'b000} +: 8] <= mem_din_i;
          state <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    load_val = load_buf;
    if (aluop_i == OP_LB)
      load_val = {{24{load_buf[7]}}, load_buf[7:0]};
    else if (aluop_i == OP_LBU)
      load_val = {24'h000000, load_buf[7:0]};
    else if (aluop_i == OP_LH)
      load_val = {{16{load_buf[15]}}, load_buf[15:0]};
    else if (aluop_i == OP_LHU)
      load_val = {16'h0000, load_buf[15:0]};
  end

  // Outputs are gated by rst so the whole port reads zero while reset is held.
  always_comb begin
    wd_o        = '0;
    wreg_o      = 1'b0;
    wdata_o     = '0;
    stall_req_o = 1'b0;
    mem_req_o   = 1'b0;
    mem_a_o     = '0;
    mem_dout_o  = '0;
    mem_wr_o    = 1'b0;
    if (rst) begin
      wd_o = wd_i;
      case (state)
        IDLE: begin
          if (is_mem) begin
            stall_req_o = 1'b1;
            mem_req_o   = 1'b1;
          end else begin
            wreg_o  = wreg_i;
            wdata_o = wdata_i;
          end
        end
        ACCESS: begin
          stall_req_o = 1'b1;
          mem_req_o   = 1'b1;
          mem_a_o     = mem_addr_i + {29'd0, cnt};
          if (is_store) begin
            mem_wr_o   = 1'b1;
            mem_dout_o = wdata_i[{cnt[1:0], 3'b000} +: 8];
          end
        end
        WAIT: begin
          stall_req_o = 1'b1;
          mem_req_o   = 1'b1;
        end
        DONE: begin
          if (is_load) begin
            wreg_o  = wreg_i;
            wdata_o = load_val;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/mem_access.md
Name: mem_access

Overview:
- Memory-access pipeline stage. Sits directly downstream of the execute stage and upstream of the MEM/WB latch.
- Consumes the execute stage's destination/write-enable/result, op code and computed memory address. Performs loads and stores through the shared byte-wide memory port, requesting that port from the memory arbiter.
- Holds the pipeline via stall_req_o until the access completes. Non-memory ops pass through combinationally.

Parameters:
AOP_W, 8, op-code width (matches the ALU op bus)
OP_LB, 8'h20, load byte, sign-extended
OP_LH, 8'h21, load half, sign-extended
OP_LW, 8'h22, load word
OP_LBU, 8'h23, load byte, zero-extended
OP_LHU, 8'h24, load half, zero-extended
OP_SB, 8'h25, store byte
OP_SH, 8'h26, store half
OP_SW, 8'h27, store word

Ports:
clk  in  1  clock
rst  in  1  reset: one clock; reset is asynchronous and active-low
wd_i  in  5  destination register
wreg_i  in  1  register write enable
wdata_i  in  32  ALU result, or store data for stores
aluop_i  in  AOP_W  op code
mem_addr_i  in  32  effective address
wd_o  out  5  to MEM/WB
wreg_o  out  1  to MEM/WB
wdata_o  out  32  to MEM/WB
stall_req_o  out  1  hold the pipeline
mem_req_o  out  1  request the memory port
mem_gnt_i  in  1  arbiter grant
mem_a_o  out  32  byte address
mem_dout_o  out  8  write byte
mem_wr_o  out  1  1 = write, 0 = read
mem_din_i  in  8  read byte, valid one cycle after its address

Behaviour:
- Reset (rst=0), asynchronous: FSM goes to IDLE, counter and load buffer clear, and every output is 0.
- Mid-operation reset aborts the access. A partially written store is left as-is.
- Byte count N: 1 for LB/LBU/SB, 2 for LH/LHU/SH, 4 for LW/SW.
- Byte k lives at address mem_addr_i+k, computed modulo 2^32 so addresses wrap. Little-endian: byte k maps to bits [8k+7:8k]. Misaligned addresses are legal.
- Non-memory op in IDLE:
  - wd_o, wreg_o, wdata_o equal their inputs.
  - stall_req_o=0, mem_req_o=0.
- IDLE with a memory op:
  - Drives stall_req_o=1 and mem_req_o=1, with mem_wr_o=0.
  - At a rising edge with mem_gnt_i=1, moves to ACCESS with cnt=0. Otherwise stays in IDLE.
- ACCESS(cnt=k):
  - Drives mem_req_o=1 and mem_a_o=addr+k.
  - Stores: mem_wr_o=1 and mem_dout_o=wdata_i[8k+7:8k].
  - Loads: mem_wr_o=0, and byte k-1 is captured from mem_din_i when k≥1.
  - cnt increments. After cnt=N-1 the FSM goes to DONE for stores, WAIT for loads.
- WAIT (loads only): captures byte N-1 from mem_din_i, then goes to DONE. mem_req_o=1, mem_wr_o=0, mem_a_o=0.
- DONE, exactly one cycle, then IDLE unconditionally:
  - stall_req_o=0, mem_req_o=0.
  - Loads: wdata_o is the assembled value, extended per op (LB: bit 7 sign, LBU: zero, LH: bit 15 sign, LHU: zero). wreg_o=wreg_i, wd_o=wd_i.
  - Stores: wreg_o=0, wdata_o=0.
  - The pipeline advances in DONE, so DONE never restarts the same op.
- Whenever stall_req_o=1: wreg_o=0. mem_a_o, mem_dout_o and mem_wr_o are 0 outside ACCESS/WAIT.
- Grant handling: once granted, the block owns the port until mem_req_o drops. mem_gnt_i is sampled only in IDLE.
- Latency, with grant in the first cycle:
  - LW: stall high for 6 cycles, DONE in cycle 7.
  - SW: stall high 5 cycles, DONE in cycle 6.
  - LB: stall high 3 cycles.
  - Each cycle of grant delay adds one.
- Inputs must stay stable while stall_req_o=1.

Test Plan:
- ALU pass-through: aluop=0, wdata_i=0x1234_5678, wd=5, wreg=1 -> same values on outputs in the same cycle; stall=0; mem_req=0.
- LW at 0x100, grant immediate, memory bytes 78,56,34,12 -> mem_a 0x100..0x103 in cycles 2-5; DONE in cycle 7 with wdata_o=0x1234_5678, wreg_o=1; stall high cycles 1-6.
- LB at 0x10 returning 0x80 -> wdata_o=0xFFFF_FF80. LBU at the same address -> 0x0000_0080. LHU of 0x80,0xFF -> 0x0000_FF80.
- SH wdata=0xAABB_CCDD at 0xFFFF_FFFF -> writes 0xDD to 0xFFFF_FFFF, then 0xCC to 0x0000_0000, with mem_wr_o=1 for exactly 2 cycles; wreg_o=0.
- SW with mem_gnt_i held low 3 cycles -> stays in IDLE with mem_req/stall high and no address driven; completes 3 cycles later than the immediate-grant case.
- rst pulled low during ACCESS cnt=2 of LW -> all outputs 0 immediately; after release, returns to IDLE and restarts the access on the held inputs.
